// File: rtl/cpc_mem_arbiter.sv
// rtl/cpc_mem_arbiter.sv - arbiter sharing the external memory port between video, CPU and loader
//
// Purpose:
//   Runs one memory transaction at a time for three requesters: 16-bit video
//   fetches, CPU byte reads/writes and loader byte writes. Arbitration happens
//   only in IDLE. The order is video first, then loader if it has waited
//   through LDR_MAX_WAIT CPU grants, then CPU, then loader. A transaction goes
//   IDLE -> ISSUE -> WAIT -> IDLE. The owner's ack pulses one cycle after
//   mem_ack.
//
// Optional feature (macro CPC_MEM_TIMEOUT_EN):
//   WAIT aborts after TIMEOUT cycles without mem_ack. The owner is still acked,
//   with read data 16'hFFFF, and the sticky mem_err flag is set. Without the
//   macro, mem_err is constant 0.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   vid_req/vid_addr            video request (level) and word address
//   vid_ack/vid_data            video completion pulse and fetched word
//   cpu_rd/cpu_wr/cpu_addr/cpu_din  CPU request (level), byte address, write data
//   cpu_dout/cpu_ack            CPU read byte (held) and completion pulse
//   ldr_wr/ldr_addr/ldr_din     loader write request (level), byte address, data
//   ldr_ack                     loader completion pulse
//   mem_req/mem_we/mem_addr/mem_be/mem_dout  memory-controller request side
//   mem_din/mem_ack             memory-controller read data and completion
//   mem_err                     sticky timeout flag
module cpc_mem_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int LDR_MAX_WAIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-2:0] vid_addr,
    output logic              vid_ack,
    output logic [15:0]       vid_data,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_ack,
    input  logic              ldr_wr,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [7:0]        ldr_din,
    output logic              ldr_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-2:0] mem_addr,
    output logic [1:0]        mem_be,
    output logic [15:0]       mem_dout,
    input  logic [15:0]       mem_din,
    input  logic              mem_ack,
    output logic              mem_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_VID = 2'd0,
        OWN_CPU = 2'd1,
        OWN_LDR = 2'd2
    } owner_t;

    localparam logic [3:0] CNT_MAX = 4'(LDR_MAX_WAIT);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic                lsb_q, lsb_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-2:0]   mem_addr_q, mem_addr_d;
    logic [1:0]          mem_be_q, mem_be_d;
    logic [15:0]         mem_dout_q, mem_dout_d;
    logic [15:0]         vid_data_q, vid_data_d;
    logic [7:0]          cpu_dout_q, cpu_dout_d;
    logic                vid_ack_q, vid_ack_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                ldr_ack_q, ldr_ack_d;
    logic [3:0]          grant_cnt_q, grant_cnt_d;

    logic                ack_busy;
    logic                done;
    logic [15:0]         rdata;

`ifdef CPC_MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                mem_err_q, mem_err_d;
`endif

    // The requester still holds its request during its ack cycle, so no grant
    // may be made then or it would be served twice.
    assign ack_busy = vid_ack_q | cpu_ack_q | ldr_ack_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_VID;
            lsb_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 2'b00;
            mem_dout_q  <= 16'h0000;
            vid_data_q  <= 16'h0000;
            cpu_dout_q  <= 8'h00;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            ldr_ack_q   <= 1'b0;
            grant_cnt_q <= 4'd0;
`ifdef CPC_MEM_TIMEOUT_EN
            tmo_q       <= '0;
            mem_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lsb_q       <= lsb_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_dout_q  <= mem_dout_d;
            vid_data_q  <= vid_data_d;
            cpu_dout_q  <= cpu_dout_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            ldr_ack_q   <= ldr_ack_d;
            grant_cnt_q <= grant_cnt_d;
`ifdef CPC_MEM_TIMEOUT_EN
            tmo_q       <= tmo_d;
            mem_err_q   <= mem_err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        lsb_d       = lsb_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_dout_d  = mem_dout_q;
        vid_data_d  = vid_data_q;
        cpu_dout_d  = cpu_dout_q;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        ldr_ack_d   = 1'b0;
        grant_cnt_d = grant_cnt_q;
        done        = 1'b0;
        rdata       = mem_din;
`ifdef CPC_MEM_TIMEOUT_EN
        tmo_d       = tmo_q;
        mem_err_d   = mem_err_q;
`endif

        // Starvation counting only matters while the loader is waiting.
        if (!ldr_wr) begin
            grant_cnt_d = 4'd0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!ack_busy) begin
                    if (vid_req) begin
                        state_d    = S_ISSUE;
                        owner_d    = OWN_VID;
                        lsb_d      = 1'b0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = vid_addr;
                        mem_be_d   = 2'b11;
                        mem_dout_d = 16'h0000;
                    end else if (ldr_wr && (grant_cnt_q == CNT_MAX)) begin
                        state_d     = S_ISSUE;
                        owner_d     = OWN_LDR;
                        lsb_d       = ldr_addr[0];
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ldr_addr[ADDR_W-1:1];
                        mem_be_d    = ldr_addr[0] ? 2'b10 : 2'b01;
                        mem_dout_d  = {ldr_din, ldr_din};
                        grant_cnt_d = 4'd0;
                    end else if (cpu_rd || cpu_wr) begin
                        state_d    = S_ISSUE;
                        owner_d    = OWN_CPU;
                        lsb_d      = cpu_addr[0];
                        // A simultaneous read and write is served as a write.
                        mem_we_d   = cpu_wr;
                        mem_addr_d = cpu_addr[ADDR_W-1:1];
                        if (cpu_wr) begin
                            mem_be_d   = cpu_addr[0] ? 2'b10 : 2'b01;
                            mem_dout_d = {cpu_din, cpu_din};
                        end else begin
                            mem_be_d   = 2'b11;
                            mem_dout_d = 16'h0000;
                        end
                        if (ldr_wr && (grant_cnt_q < CNT_MAX)) begin
                            grant_cnt_d = grant_cnt_q + 4'd1;
                        end
                    end else if (ldr_wr) begin
                        state_d     = S_ISSUE;
                        owner_d     = OWN_LDR;
                        lsb_d       = ldr_addr[0];
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ldr_addr[ADDR_W-1:1];
                        mem_be_d    = ldr_addr[0] ? 2'b10 : 2'b01;
                        mem_dout_d  = {ldr_din, ldr_din};
                        grant_cnt_d = 4'd0;
                    end
                end
            end
            S_ISSUE: begin
                mem_req_d = 1'b1;
                state_d   = S_WAIT;
`ifdef CPC_MEM_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end
            S_WAIT: begin
                if (mem_ack) begin
                    done = 1'b1;
`ifdef CPC_MEM_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    done      = 1'b1;
                    rdata     = 16'hFFFF;
                    mem_err_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
            case (owner_q)
                OWN_VID: begin
                    vid_ack_d  = 1'b1;
                    vid_data_d = rdata;
                end
                OWN_CPU: begin
                    cpu_ack_d = 1'b1;
                    if (!mem_we_q) begin
                        cpu_dout_d = lsb_q ? rdata[15:8] : rdata[7:0];
                    end
                end
                default: begin
                    ldr_ack_d = 1'b1;
                end
            endcase
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_be   = mem_be_q;
    assign mem_dout = mem_dout_q;
    assign vid_data = vid_data_q;
    assign cpu_dout = cpu_dout_q;
    assign vid_ack  = vid_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign ldr_ack  = ldr_ack_q;

`ifdef CPC_MEM_TIMEOUT_EN
    assign mem_err = mem_err_q;
`else
    // TIMEOUT has no effect in this build; the comparison is always false.
    assign mem_err = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

endmodule

// File: tb/tb_cpc_mem_arbiter.sv
// tb/tb_cpc_mem_arbiter.sv - randomized self-checking bench for cpc_mem_arbiter
module tb_cpc_mem_arbiter;

    localparam int ADDR_W = 23;
    localparam int MAXW   = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              vid_req = 1'b0;
    logic [ADDR_W-2:0] vid_addr = '0;
    logic              vid_ack;
    logic [15:0]       vid_data;
    logic              cpu_rd = 1'b0;
    logic              cpu_wr = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [7:0]        cpu_din = '0;
    logic [7:0]        cpu_dout;
    logic              cpu_ack;
    logic              ldr_wr = 1'b0;
    logic [ADDR_W-1:0] ldr_addr = '0;
    logic [7:0]        ldr_din = '0;
    logic              ldr_ack;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-2:0] mem_addr;
    logic [1:0]        mem_be;
    logic [15:0]       mem_dout;
    logic [15:0]       mem_din = '0;
    logic              mem_ack = 1'b0;
    logic              mem_err;

    cpc_mem_arbiter #(.ADDR_W(ADDR_W), .LDR_MAX_WAIT(MAXW), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_data(vid_data),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .ldr_wr(ldr_wr), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_ack(ldr_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: transaction-level view of the arbiter
    int          edge_n, req_edge, free_edge, mcnt, own;
    bit          inflight;
    bit          e_we, e_lsb;
    logic [21:0] e_addr;
    logic [1:0]  e_be;
    logic [15:0] e_dout;
    logic [7:0]  exp_cpu_dout;

    // Inputs as they will be sampled at the coming edge
    bit          s_vid, s_crd, s_cwr, s_ldr, s_mack;
    logic [21:0] s_vaddr;
    logic [22:0] s_caddr, s_laddr;
    logic [7:0]  s_cdin, s_ldin;
    logic [15:0] s_mdin;

    // Stimulus controls
    int          p_vid = 0, p_cpu = 0, p_ldr = 0;
    bit          force_en = 0;
    logic [15:0] force_din = '0;
    int          force_dly = 0;
    int          mcount = 0, mdly = 0;
    int          n_cack = 0, first_ack = -1;
    bit          count_runs = 0, seen_ldr = 0;
    int          run = 0, nruns = 0;
    bit          seen_we;
    logic [1:0]  seen_be;
    logic [21:0] seen_addr;
    logic [15:0] seen_dout;

    task automatic model_init();
        edge_n = 0; free_edge = 1; inflight = 0; mcnt = 0; exp_cpu_dout = 8'h00;
        req_edge = 0; own = 0;
    endtask

    task automatic cycle();
        bit av, ac, al;
        int k;
        s_vid = vid_req; s_crd = cpu_rd; s_cwr = cpu_wr; s_ldr = ldr_wr; s_mack = mem_ack;
        s_vaddr = vid_addr; s_caddr = cpu_addr; s_laddr = ldr_addr;
        s_cdin = cpu_din; s_ldin = ldr_din; s_mdin = mem_din;
        @(negedge clk);
        edge_n++;
        av = 0; ac = 0; al = 0;
        if (inflight && edge_n > req_edge && s_mack) begin
            inflight = 0;
            free_edge = edge_n + 2;
            if (own == 0) begin
                av = 1;
                check("vid_data", vid_data, s_mdin);
            end else if (own == 1) begin
                ac = 1;
                if (!e_we) exp_cpu_dout = e_lsb ? s_mdin[15:8] : s_mdin[7:0];
            end else begin
                al = 1;
            end
        end
        if (!s_ldr) mcnt = 0;
        if (!inflight && edge_n >= free_edge && (s_vid || s_crd || s_cwr || s_ldr)) begin
            inflight = 1;
            req_edge = edge_n + 1;
            if (s_vid) begin
                own = 0; e_we = 0; e_addr = s_vaddr; e_be = 2'b11; e_lsb = 0; e_dout = 0;
            end else if ((s_ldr && mcnt == MAXW) || (s_ldr && !s_crd && !s_cwr)) begin
                own = 2; e_we = 1; e_addr = s_laddr[22:1]; e_lsb = s_laddr[0];
                e_be = s_laddr[0] ? 2'b10 : 2'b01; e_dout = {s_ldin, s_ldin};
                mcnt = 0;
            end else begin
                own = 1; e_we = s_cwr; e_addr = s_caddr[22:1]; e_lsb = s_caddr[0];
                e_be = s_cwr ? (s_caddr[0] ? 2'b10 : 2'b01) : 2'b11;
                e_dout = {s_cdin, s_cdin};
                if (s_ldr) mcnt = (mcnt < MAXW) ? mcnt + 1 : MAXW;
            end
        end
        check("mem_req", mem_req, inflight && edge_n >= req_edge);
        if (inflight && edge_n >= req_edge) begin
            check("mem_we", mem_we, e_we);
            check("mem_addr", mem_addr, e_addr);
            check("mem_be", mem_be, e_be);
            if (e_we) check("mem_dout", mem_dout, e_dout);
        end
        if (mem_req) begin
            seen_we = mem_we; seen_be = mem_be; seen_addr = mem_addr; seen_dout = mem_dout;
        end
        check("vid_ack", vid_ack, av);
        check("cpu_ack", cpu_ack, ac);
        check("ldr_ack", ldr_ack, al);
        check("cpu_dout", cpu_dout, exp_cpu_dout);
        check("mem_err", mem_err, 1'b0);

        if (cpu_ack) n_cack++;
        if (first_ack < 0 && vid_ack) first_ack = 0;
        else if (first_ack < 0 && cpu_ack) first_ack = 1;
        if (count_runs) begin
            if (cpu_ack) run++;
            if (ldr_ack) begin
                if (seen_ldr) begin
                    check("cpu_run_len", run, MAXW);
                    nruns++;
                end
                seen_ldr = 1;
                run = 0;
            end
        end

        // Requesters drop on their ack and may re-request at once
        if (vid_ack) vid_req = 0;
        if (cpu_ack) begin cpu_rd = 0; cpu_wr = 0; end
        if (ldr_ack) ldr_wr = 0;
        if (!vid_req && $urandom_range(99) < p_vid) begin
            vid_req = 1; vid_addr = 22'($urandom);
        end
        if (!cpu_rd && !cpu_wr && $urandom_range(99) < p_cpu) begin
            k = $urandom_range(9);
            cpu_rd = (k < 5) || (k == 9);
            cpu_wr = (k >= 5);
            cpu_addr = 23'($urandom); cpu_din = 8'($urandom);
        end
        if (!ldr_wr && $urandom_range(99) < p_ldr) begin
            ldr_wr = 1; ldr_addr = 23'($urandom); ldr_din = 8'($urandom);
        end

        // Memory controller: ack mdly cycles after mem_req, occasional stray acks
        if (mem_ack) begin
            mem_ack = 0;
        end else if (mem_req) begin
            if (mcount >= mdly) begin
                mem_ack = 1;
                mem_din = force_en ? force_din : 16'($urandom);
                mcount = 0;
                mdly = force_en ? force_dly : $urandom_range(5);
            end else begin
                mcount++;
            end
        end else begin
            mcount = 0;
            if (!force_en && $urandom_range(99) < 5) begin
                mem_ack = 1; mem_din = 16'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        vid_req = 0; cpu_rd = 0; cpu_wr = 0; ldr_wr = 0; mem_ack = 0; mcount = 0;
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 22'h0);
        check("rst_mem_be", mem_be, 2'b00);
        check("rst_mem_dout", mem_dout, 16'h0);
        check("rst_vid_data", vid_data, 16'h0);
        check("rst_cpu_dout", cpu_dout, 8'h0);
        check("rst_acks", {vid_ack, cpu_ack, ldr_ack}, 3'b000);
        check("rst_mem_err", mem_err, 1'b0);
        repeat (2) @(negedge clk);
        reset = 0;
        model_init();
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        p_vid = 0; p_cpu = 0; p_ldr = 0;
        while ((vid_req || cpu_rd || cpu_wr || ldr_wr || inflight) && n < lim) begin
            cycle();
            n++;
        end
        check("drain_bound", n < lim, 1'b1);
    endtask

    initial begin
        int n0, n;
        mdly = 0;
        do_reset();
        repeat (3) cycle();

        // Single CPU read, ack 3 cycles after mem_req
        force_en = 1; force_din = 16'hA55A; force_dly = 3; mdly = 3;
        cpu_rd = 1; cpu_addr = 23'h000101;
        n0 = n_cack;
        drain(40);
        check("rd_addr", seen_addr, 22'h000080);
        check("rd_we", seen_we, 1'b0);
        check("rd_dout", cpu_dout, 8'hA5);
        check("rd_ack_cnt", n_cack - n0, 1);

        // Single CPU write to an even byte
        cpu_wr = 1; cpu_addr = 23'h000200; cpu_din = 8'h3C;
        n0 = n_cack;
        drain(40);
        check("wr_we", seen_we, 1'b1);
        check("wr_be", seen_be, 2'b01);
        check("wr_dout", seen_dout, 16'h3C3C);
        check("wr_ack_cnt", n_cack - n0, 1);

        // Video and CPU together: video first
        force_din = 16'h1234; force_dly = 1; mdly = 1;
        vid_req = 1; vid_addr = 22'h000155;
        cpu_rd = 1; cpu_addr = 23'h000006;
        first_ack = -1;
        drain(40);
        check("vid_first", first_ack, 0);
        check("vid_word", vid_data, 16'h1234);
        check("cpu_after_vid", cpu_dout, 8'h34);
        force_en = 0;

        // Random mix
        p_vid = 25; p_cpu = 50; p_ldr = 30;
        repeat (3000) cycle();
        drain(200);

        // Loader held against a continuously re-requesting CPU
        p_vid = 0; p_cpu = 100; p_ldr = 100;
        count_runs = 1; seen_ldr = 0; run = 0; nruns = 0;
        repeat (400) cycle();
        count_runs = 0;
        drain(100);
        check("ldr_runs_seen", nruns >= 5, 1'b1);

        // Reset while in WAIT
        cpu_rd = 1; cpu_addr = 23'($urandom);
        n = 0;
        while (!mem_req && n < 20) begin
            cycle();
            n++;
        end
        check("wait_reached", mem_req, 1'b1);
        reset = 1;
        #1;
        check("rst_wait_req", mem_req, 1'b0);
        check("rst_wait_acks", {vid_ack, cpu_ack, ldr_ack}, 3'b000);
        do_reset();
        repeat (6) cycle();
        cpu_rd = 1; cpu_addr = 23'h000011;
        n0 = n_cack;
        drain(40);
        check("rerequest_ack", n_cack - n0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
